// File: rtl/rr_mux_n_if.sv
// Handshake bundle for rr_mux_n: N producer channels in, one consumer out.
// slave is the mux side, master is the producer/consumer side.
interface rr_mux_n_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_mux_n.sv
// N-channel registered mux with round-robin arbitration and valid/ready on all sides.
// Define RR_MUX_FIXED_PRI_EN for fixed lowest-index-first priority (no rotating pointer).
module rr_mux_n #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input logic         clk,
  input logic         rst,
  input logic         ena,
  rr_mux_n_if.slave   bus
);

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;

  logic          load;
  logic [SW-1:0] start;
  logic [SW:0]   sum;
  logic [SW-1:0] idx;
  logic          found;
  logic [SW-1:0] gnt_idx;
  logic [N-1:0]  gnt;
  logic [W-1:0]  gnt_data;

  // Output register can take a new beat when empty or draining this cycle
  assign load = ena & ~rst & (~out_valid_q | bus.out_ready);

`ifdef RR_MUX_FIXED_PRI_EN
  assign start = '0;
`else
  logic [SW-1:0] ptr;
  assign start = ptr;
`endif

  // Scan channels from start, wrapping mod N; first valid channel wins
  always_comb begin
    sum     = '0;
    idx     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    if (load) begin
      for (int unsigned k = 0; k < N; k++) begin
        sum = {1'b0, start} + (SW+1)'(k);
        if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
        idx = SW'(sum);
        if (!found && bus.in_valid[idx]) begin
          found   = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

  always_comb begin
    gnt      = '0;
    gnt_data = '0;
    if (found) gnt[gnt_idx] = 1'b1;
    for (int unsigned c = 0; c < N; c++) begin
      if (gnt[c]) gnt_data = bus.in_data[c*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (found) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_data;
      out_sel_q   <= gnt_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifndef RR_MUX_FIXED_PRI_EN
  // Pointer moves just past the granted channel so it has lowest priority next
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
    end
  end
`endif

  assign bus.in_ready  = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed vector bench for rr_mux_n (N=4, W=8).
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  rr_mux_n_if #(.N(4), .W(8)) bus ();

  rr_mux_n #(.N(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ena;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_os;
  } vec_t;

  localparam logic [31:0] DN = 32'h0D0C0B0A;  // ch3..ch0 = 13,12,11,10
  localparam logic [31:0] DA = 32'h0DA50B0A;  // ch2 = A5

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check in_ready before the edge and registers after it
  task automatic run_vec(input int i, input vec_t v);
    rst              = v.rst;
    ena              = v.ena;
    bus.in_valid     = v.vld;
    bus.in_data      = v.data;
    bus.out_ready    = v.ordy;
    #1;
    chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(v.exp_ov));
    chk($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(v.exp_od));
    chk($sformatf("v%0d out_sel", i), 32'(bus.out_sel), 32'(v.exp_os));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1;
    bus.in_valid = '0; bus.in_data = DN; bus.out_ready = 1'b1;
    #1;

`ifdef RR_MUX_FIXED_PRI_EN
    //           rst  ena  vld      data ordy rdy      ov    od     os
    tv.push_back('{1'b1,1'b1,4'b1111,DN,1'b1,4'b0000,1'b0,8'h00,2'd0});
    tv.push_back('{1'b1,1'b1,4'b1111,DN,1'b1,4'b0000,1'b0,8'h00,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0001,1'b1,8'h0A,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0001,1'b1,8'h0A,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0001,1'b1,8'h0A,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1110,DN,1'b1,4'b0010,1'b1,8'h0B,2'd1});
    tv.push_back('{1'b0,1'b1,4'b1100,DN,1'b1,4'b0100,1'b1,8'h0C,2'd2});
    for (int i = 0; i < tv.size(); i++) run_vec(i, tv[i]);
`else
    //           rst  ena  vld      data ordy rdy      ov    od     os
    // reset held with all channels valid
    tv.push_back('{1'b1,1'b1,4'b1111,DN,1'b1,4'b0000,1'b0,8'h00,2'd0});
    tv.push_back('{1'b1,1'b1,4'b1111,DN,1'b1,4'b0000,1'b0,8'h00,2'd0});
    // single channel 2, then drain with data/sel holding
    tv.push_back('{1'b0,1'b1,4'b0100,DA,1'b1,4'b0100,1'b1,8'hA5,2'd2});
    tv.push_back('{1'b0,1'b1,4'b0000,DA,1'b1,4'b0000,1'b0,8'hA5,2'd2});
    // ptr=3: channel 3 alone brings ptr back to 0
    tv.push_back('{1'b0,1'b1,4'b1000,DN,1'b1,4'b1000,1'b1,8'h0D,2'd3});
    // all valid: 0,1,2,3,0
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0001,1'b1,8'h0A,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0010,1'b1,8'h0B,2'd1});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0100,1'b1,8'h0C,2'd2});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b1000,1'b1,8'h0D,2'd3});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0001,1'b1,8'h0A,2'd0});
    // stall three cycles, then release grants next channel (1)
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b0,4'b0000,1'b1,8'h0A,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b0,4'b0000,1'b1,8'h0A,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b0,4'b0000,1'b1,8'h0A,2'd0});
    tv.push_back('{1'b0,1'b1,4'b1111,DN,1'b1,4'b0010,1'b1,8'h0B,2'd1});
    // ena=0: drain, no grants
    tv.push_back('{1'b0,1'b0,4'b1111,DN,1'b1,4'b0000,1'b0,8'h0B,2'd1});
    tv.push_back('{1'b0,1'b0,4'b1111,DN,1'b1,4'b0000,1'b0,8'h0B,2'd1});
    // ptr=2, only 0/1 valid: scan wraps to 0
    tv.push_back('{1'b0,1'b1,4'b0011,DN,1'b1,4'b0001,1'b1,8'h0A,2'd0});
    // ptr=1, 0/3 valid: grant 3, ptr wraps to 0
    tv.push_back('{1'b0,1'b1,4'b1001,DN,1'b1,4'b1000,1'b1,8'h0D,2'd3});
    tv.push_back('{1'b0,1'b1,4'b1001,DN,1'b1,4'b0001,1'b1,8'h0A,2'd0});
    // mid-stream reset drops the beat and clears ptr
    tv.push_back('{1'b1,1'b1,4'b1111,DN,1'b1,4'b0000,1'b0,8'h00,2'd0});
    tv.push_back('{1'b0,1'b1,4'b0010,DN,1'b1,4'b0010,1'b1,8'h0B,2'd1});
    for (int i = 0; i < tv.size(); i++) run_vec(i, tv[i]);

    // Hand sequence: valid withdrawn during a stall, then drain with nothing valid
    bus.out_ready = 1'b0; bus.in_valid = 4'b0100;
    #1;
    chk("stall withdraw in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk); #1;
    chk("stall withdraw out_data", 32'(bus.out_data), 32'h0B);
    bus.in_valid = 4'b0000; bus.out_ready = 1'b1;
    #1;
    chk("drain in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk); #1;
    chk("drain out_valid", 32'(bus.out_valid), 32'h0);
    chk("drain out_sel", 32'(bus.out_sel), 32'h1);
    // ptr should now be 2
    bus.in_valid = 4'b0101;
    #1;
    chk("ptr after drain in_ready", 32'(bus.in_ready), 32'h4);
    @(posedge clk); #1;
    chk("ptr after drain out_data", 32'(bus.out_data), 32'h0C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
